chess_clock_core: RTL

Parametrised timing core for the chess clock: holds a per-player remaining-time counter for N_PLAYERS players, decrements the active player's time once per second, and advances the turn on each move press. It supports three time-control modes: sudden death, Fischer increment and Bronstein delay. It replaces the fixed two-player counter path and sits between the button/debounce front end and the BCD/7-segment display driver, which reads times through DISP_SEL/DISP_TIME.

---
 rtl/chess_clock_core.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/chess_clock_core.sv
// Multi-player chess clock timing core: per-player seconds counters with sudden death, Fischer and Bronstein.
// All state updates land one cycle after the causing edge; DISP_TIME is a zero-latency mux. No backpressure.
module chess_clock_core #(
   parameter int N_PLAYERS     = 2,
   parameter int TIME_W        = 14,
   parameter int INC_W         = 6,
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int INIT_TIME     = 300,
   localparam int SEL_W        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
   input  logic                 CLK,
   input  logic                 CLR_N,
   input  logic                 CE,
   input  logic                 STOP,
   input  logic                 SELECT,
   input  logic [1:0]           MODE,
   input  logic [INC_W-1:0]     INC,
   input  logic                 LOAD,
   input  logic [TIME_W-1:0]    LOAD_TIME,
   input  logic [SEL_W-1:0]     DISP_SEL,
   output logic [TIME_W-1:0]    DISP_TIME,
   output logic [SEL_W-1:0]     ACTIVE,
   output logic [N_PLAYERS-1:0] FLAG,
   output logic                 RUNNING,
   output logic                 GAME_OVER
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]    PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
   localparam logic [SEL_W-1:0] LAST_PLAYER = SEL_W'(N_PLAYERS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_OVER} state_t;

   state_t               r_state;
   logic [TIME_W-1:0]    r_time [N_PLAYERS];
   logic [SEL_W-1:0]     r_active;
   logic [N_PLAYERS-1:0] r_flag;
   logic [PW-1:0]        r_presc;
   logic [INC_W-1:0]     r_delay;
   logic                 r_sel_q;
   logic                 r_running;
   logic                 r_over;

   logic                 w_move;
   logic                 w_cnt;
   logic                 w_wrap;
   logic                 w_tick;
   logic                 w_hold;
   logic                 w_norm;
   logic                 w_flag_now;
   logic [TIME_W-1:0]    w_cur;
   logic [TIME_W-1:0]    w_after_tick;
   logic [TIME_W:0]      w_sum;
   logic [TIME_W-1:0]    w_fischer;
   logic [SEL_W-1:0]     w_next_active;

   assign w_move        = SELECT & ~r_sel_q;
   // A STOP cycle neither counts nor ticks, so a wrap pending at pause is taken on resume.
   assign w_cnt         = CE & ~STOP;
   assign w_wrap        = (r_presc == PRESC_MAX);
   assign w_tick        = (r_state == ST_RUN) & w_cnt & w_wrap;
   assign w_hold        = w_tick & (MODE == 2'b10) & (r_delay < INC);
   assign w_norm        = w_tick & ~w_hold;
   assign w_cur         = r_time[r_active];
   assign w_flag_now    = w_norm & (w_cur <= TIME_W'(1));
   assign w_after_tick  = w_norm ? (w_cur - 1'b1) : w_cur;
   assign w_sum         = {1'b0, w_after_tick} + {{(TIME_W + 1 - INC_W){1'b0}}, INC};
   assign w_fischer     = w_sum[TIME_W] ? '1 : w_sum[TIME_W-1:0];
   assign w_next_active = (r_active == LAST_PLAYER) ? '0 : r_active + 1'b1;

   assign DISP_TIME = (int'(DISP_SEL) < N_PLAYERS) ? r_time[DISP_SEL] : '0;
   assign ACTIVE    = r_active;
   assign FLAG      = r_flag;
   assign RUNNING   = r_running;
   assign GAME_OVER = r_over;

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         for (int i = 0; i < N_PLAYERS; i++) r_time[i] <= TIME_W'(INIT_TIME);
         r_state   <= ST_IDLE;
         r_active  <= '0;
         r_flag    <= '0;
         r_presc   <= '0;
         r_delay   <= '0;
         r_sel_q   <= 1'b0;
         r_running <= 1'b0;
         r_over    <= 1'b0;
      end else begin
         r_sel_q <= SELECT;
         if (LOAD && (r_state != ST_RUN)) begin
            for (int i = 0; i < N_PLAYERS; i++) r_time[i] <= LOAD_TIME;
            r_flag    <= '0;
            r_active  <= '0;
            r_presc   <= '0;
            r_delay   <= '0;
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_over    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_move && !STOP) begin
                     r_state   <= ST_RUN;
                     r_running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // A flagging tick beats a simultaneous move: no increment, no turn change.
                  if (w_flag_now) begin
                     r_time[r_active] <= '0;
                     r_flag[r_active] <= 1'b1;
                     r_state          <= ST_OVER;
                     r_running        <= 1'b0;
                     r_over           <= 1'b1;
                  end else begin
                     if (w_hold) r_delay <= r_delay + 1'b1;
                     if (w_move) begin
                        r_time[r_active] <= (MODE == 2'b01) ? w_fischer : w_after_tick;
                        r_active         <= w_next_active;
                        r_presc          <= '0;
                        r_delay          <= '0;
                     end else begin
                        r_time[r_active] <= w_after_tick;
                        if (w_cnt) r_presc <= w_wrap ? '0 : r_presc + 1'b1;
                     end
                     if (STOP) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                     end
                  end
               end
               ST_PAUSED: begin
                  if (!STOP) begin
                     r_state   <= ST_RUN;
                     r_running <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
